// File: rtl/mm_pkg.sv
// Shared parameters and types for the 8x8 tiled matrix multiply datapath.
package mm_pkg;

  localparam int unsigned DIM    = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 19;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TILE   = 2;
  localparam int unsigned IDX_W  = $clog2(DIM);
  localparam int unsigned K_W    = $clog2(DIM);
  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef struct packed {
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
  } tile_coord_t;

  // Row-major C memory address of element (row, col).
  function automatic logic [ADDR_W-1:0] c_addr_of(input logic [IDX_W-1:0] row,
                                                  input logic [IDX_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(DIM) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/mac_cell.sv
// One signed multiply-accumulate lane; sum_c is the value the accumulator takes this cycle.
module mac_cell
  import mm_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_i,
  input  logic                     load_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  sum_c
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q;

  assign prod     = a_i * b_i;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  // First k of a tile loads the product so no stale sum leaks in.
  assign sum_c    = load_i ? prod_ext : acc_q + prod_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_c;
    end
  end

endmodule

// File: rtl/mac2x2_c_writer.sv
// Accumulates 2x2 C tiles over k and drains each finished tile into C memory as four writes.
module mac2x2_c_writer
  import mm_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] a1,
  input  logic signed [DATA_W-1:0] a2,
  input  logic signed [DATA_W-1:0] b1,
  input  logic signed [DATA_W-1:0] b2,
  output logic                     c_we,
  output logic [ADDR_W-1:0]        c_addr,
  output logic signed [ACC_W-1:0]  c_data,
  output logic                     busy,
  output logic                     done
);

  logic [K_W-1:0]           k_q, k_d;
  tile_coord_t              tile_q, tile_d, tile_next;
  tile_coord_t              base_q, base_d;
  logic                     fin_q, fin_d;
  logic                     drain_act_q, drain_act_d;
  logic [1:0]               drain_idx_q, drain_idx_d;
  logic signed [ACC_W-1:0]  drain_q [4];
  logic signed [ACC_W-1:0]  drain_d [4];
  logic                     last_wr_q, last_wr_d;
  logic                     c_we_q, c_we_d;
  logic [ADDR_W-1:0]        c_addr_q, c_addr_d;
  logic signed [ACC_W-1:0]  c_data_q, c_data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     accept, load, capture, last_tile;
  logic signed [ACC_W-1:0]  sum_c [4];

  // Once the final tile is captured, further operands are ignored.
  assign accept    = in_valid & ~fin_q;
  assign load      = (k_q == '0);
  assign capture   = accept & (k_q == K_W'(DIM - 1));
  assign last_tile = (tile_q.i == IDX_W'(DIM - TILE)) & (tile_q.j == IDX_W'(DIM - TILE));

  mac_cell u_mac00 (.clk(clk), .reset(reset), .en_i(accept), .load_i(load), .a_i(a1), .b_i(b1), .sum_c(sum_c[0]));
  mac_cell u_mac01 (.clk(clk), .reset(reset), .en_i(accept), .load_i(load), .a_i(a1), .b_i(b2), .sum_c(sum_c[1]));
  mac_cell u_mac10 (.clk(clk), .reset(reset), .en_i(accept), .load_i(load), .a_i(a2), .b_i(b1), .sum_c(sum_c[2]));
  mac_cell u_mac11 (.clk(clk), .reset(reset), .en_i(accept), .load_i(load), .a_i(a2), .b_i(b2), .sum_c(sum_c[3]));

  // Tile walk: j inner, i outer, both by TILE.
  always_comb begin
    tile_next = tile_q;
    if (tile_q.j == IDX_W'(DIM - TILE)) begin
      tile_next.j = '0;
      tile_next.i = tile_q.i + IDX_W'(TILE);
    end else begin
      tile_next.j = tile_q.j + IDX_W'(TILE);
    end
  end

  always_comb begin
    k_d         = k_q;
    tile_d      = tile_q;
    base_d      = base_q;
    fin_d       = fin_q;
    drain_act_d = drain_act_q;
    drain_idx_d = drain_idx_q;
    drain_d     = drain_q;
    last_wr_d   = 1'b0;
    c_we_d      = 1'b0;
    c_addr_d    = c_addr_q;
    c_data_d    = c_data_q;
    done_d      = done_q | last_wr_q;

    if (accept) begin
      k_d = capture ? '0 : k_q + K_W'(1);
    end

    if (capture) begin
      // Element (i,j) is written straight from the adders; the other three wait in the buffer.
      tile_d      = tile_next;
      base_d      = tile_q;
      fin_d       = last_tile;
      drain_d     = sum_c;
      drain_act_d = 1'b1;
      drain_idx_d = 2'd1;
      c_we_d      = 1'b1;
      c_addr_d    = c_addr_of(tile_q.i, tile_q.j);
      c_data_d    = sum_c[0];
    end else if (drain_act_q) begin
      c_we_d      = 1'b1;
      c_addr_d    = c_addr_of(base_q.i + IDX_W'(drain_idx_q[1]), base_q.j + IDX_W'(drain_idx_q[0]));
      c_data_d    = drain_q[drain_idx_q];
      drain_idx_d = drain_idx_q + 2'd1;
      if (drain_idx_q == 2'd3) begin
        drain_act_d = 1'b0;
        last_wr_d   = fin_q;
      end
    end

    busy_d = (k_d != '0) | c_we_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q         <= '0;
      tile_q      <= '0;
      base_q      <= '0;
      fin_q       <= 1'b0;
      drain_act_q <= 1'b0;
      drain_idx_q <= '0;
      for (int n = 0; n < 4; n++) drain_q[n] <= '0;
      last_wr_q   <= 1'b0;
      c_we_q      <= 1'b0;
      c_addr_q    <= '0;
      c_data_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      k_q         <= k_d;
      tile_q      <= tile_d;
      base_q      <= base_d;
      fin_q       <= fin_d;
      drain_act_q <= drain_act_d;
      drain_idx_q <= drain_idx_d;
      drain_q     <= drain_d;
      last_wr_q   <= last_wr_d;
      c_we_q      <= c_we_d;
      c_addr_q    <= c_addr_d;
      c_data_q    <= c_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign c_we   = c_we_q;
  assign c_addr = c_addr_q;
  assign c_data = c_data_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifndef SYNTHESIS
  // A tile cannot complete while the previous tile is still draining.
  assert property (@(posedge clk) disable iff (reset) !(capture && drain_act_q))
    else $error("tile capture while drain active");
`endif

endmodule

// File: tb/tb_mac2x2_c_writer.sv
// Directed checks of the 2x2 tile MAC / C writer over full 8x8 products.
module tb_mac2x2_c_writer;
  import mm_pkg::*;

  logic                     clk;
  logic                     reset;
  logic                     in_valid;
  logic signed [DATA_W-1:0] a1, a2, b1, b2;
  logic                     c_we;
  logic [ADDR_W-1:0]        c_addr;
  logic signed [ACC_W-1:0]  c_data;
  logic                     busy;
  logic                     done;

  mac2x2_c_writer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .c_we(c_we), .c_addr(c_addr), .c_data(c_data),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int c;
  } wr_t;

  typedef struct {
    int a1, a2, b1, b2;
    int e00, e01, e10, e11;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  logic done_seen = 1'b0;
  wr_t  wr_q[$];
  int   A [8][8];
  int   B [8][8];
  int   exp_c [64];
  int   v8_cyc;
  int   gap_busy_bad;
  vec_t tbl [5];

  always @(posedge clk) cyc <= cyc + 1;

  // Write logger and done-rise timestamp.
  always @(negedge clk) begin
    if (c_we) wr_q.push_back('{int'(c_addr), int'(c_data), cyc});
    if (done && !done_seen) done_cyc = cyc;
    done_seen = done;
  end

  task automatic check(input string name, input int got, input int expv);
    n_vec++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Feeds operands in the upstream generator's tile/k order.
  task automatic drive_mm(input bit stall, input int stop_after);
    int nv;
    int ti;
    int tj;
    int gaps;
    nv = 0;
    for (int t = 0; t < 16; t++) begin
      for (int k = 0; k < 8; k++) begin
        ti = (t / 4) * 2;
        tj = (t % 4) * 2;
        if (stall) begin
          gaps = 0;
          while (gaps < 4 && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            if (k > 0 && busy !== 1'b1) gap_busy_bad++;
            gaps++;
            @(posedge clk);
            #1;
          end
        end
        a1 = 8'(A[ti][k]);
        a2 = 8'(A[ti+1][k]);
        b1 = 8'(B[k][tj]);
        b2 = 8'(B[k][tj+1]);
        in_valid = 1'b1;
        nv++;
        if (nv == 8) v8_cyc = cyc;
        @(posedge clk);
        #1;
        if (nv == stop_after) begin
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int w = 0; w < 20 && done !== 1'b1; w++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_run(input int base, input string tag);
    int got [64];
    int n;
    int first8 [8];
    int last4 [4];
    first8 = '{0, 1, 8, 9, 2, 3, 10, 11};
    last4  = '{54, 55, 62, 63};
    n = wr_q.size() - base;
    check({tag, " write count"}, n, 64);
    for (int a = 0; a < 64; a++) got[a] = -999999;
    for (int e = base; e < wr_q.size(); e++)
      if (wr_q[e].addr < 64) got[wr_q[e].addr] = wr_q[e].data;
    for (int a = 0; a < 64; a++)
      check($sformatf("%s C[%0d][%0d]", tag, a / 8, a % 8), got[a], exp_c[a]);
    if (n >= 12) begin
      for (int s = 0; s < 8; s++)
        check($sformatf("%s order[%0d]", tag, s), wr_q[base+s].addr, first8[s]);
      for (int s = 0; s < 4; s++)
        check($sformatf("%s order[end-%0d]", tag, 3 - s), wr_q[wr_q.size()-4+s].addr, last4[s]);
      check({tag, " done timing"}, done_cyc, wr_q[wr_q.size()-1].c + 1);
    end
    check({tag, " done"}, int'(done), 1);
    check({tag, " busy idle"}, int'(busy), 0);
  endtask

  task automatic load_identity();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        A[r][c] = (r == c) ? 1 : 0;
        B[r][c] = r * 8 + c;
      end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        exp_c[r*8+c] = 0;
        for (int k = 0; k < 8; k++) exp_c[r*8+c] += A[r][k] * B[k][c];
      end
  endtask

  initial begin
    int base;
    int base2;
    int hit2;

    tbl[0] = '{-128, -128, -128, -128, 131072, 131072, 131072, 131072};
    tbl[1] = '{127, 127, -128, -128, -130048, -130048, -130048, -130048};
    tbl[2] = '{2, -3, 5, 7, 80, 112, -120, -168};
    tbl[3] = '{1, -1, 1, -1, 8, -8, -8, 8};
    tbl[4] = '{127, -128, 127, -128, 129032, -130048, -130048, 131072};

    reset = 1'b1;
    in_valid = 1'b0;
    a1 = '0; a2 = '0; b1 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset c_we", int'(c_we), 0);
    check("reset c_addr", int'(c_addr), 0);
    check("reset c_data", int'(c_data), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);

    // Constant-per-parity operand tables with hand-computed tile values.
    for (int v = 0; v < 5; v++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          A[r][c] = (r % 2 == 0) ? tbl[v].a1 : tbl[v].a2;
          B[r][c] = (c % 2 == 0) ? tbl[v].b1 : tbl[v].b2;
          exp_c[r*8+c] = (r % 2 == 0) ? ((c % 2 == 0) ? tbl[v].e00 : tbl[v].e01)
                                      : ((c % 2 == 0) ? tbl[v].e10 : tbl[v].e11);
        end
      do_reset();
      base = wr_q.size();
      drive_mm(1'b0, -1);
      wait_done();
      check_run(base, $sformatf("vec%0d", v));
    end

    // Identity, continuous valid, first-write latency.
    load_identity();
    do_reset();
    base = wr_q.size();
    drive_mm(1'b0, -1);
    wait_done();
    check_run(base, "ident");
    check("ident first write cycle", wr_q[base].c, v8_cyc + 1);
    check("ident first addr", wr_q[base].addr, 0);
    check("ident first data", wr_q[base].data, 0);

    // Operands after done are ignored.
    base2 = wr_q.size();
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 in_valid = 1'b0;
    check("postdone writes", wr_q.size() - base2, 0);
    check("postdone done", int'(done), 1);
    check("postdone c_we", int'(c_we), 0);

    // Identity with random valid gaps.
    do_reset();
    gap_busy_bad = 0;
    base = wr_q.size();
    drive_mm(1'b1, -1);
    wait_done();
    check_run(base, "stall");
    check("stall busy in gaps", gap_busy_bad, 0);

    // Reset at k=3 of tile (0,2), during the last write of tile (0,0).
    do_reset();
    base = wr_q.size();
    drive_mm(1'b0, 11);
    check("midreset c_we before", int'(c_we), 1);
    check("midreset c_addr before", int'(c_addr), 9);
    reset = 1'b1;
    #1;
    check("midreset c_we drop", int'(c_we), 0);
    check("midreset busy drop", int'(busy), 0);
    hit2 = 0;
    for (int e = base; e < wr_q.size(); e++) if (wr_q[e].addr == 2) hit2++;
    check("midreset no addr2", hit2, 0);
    @(posedge clk);
    #1;
    do_reset();
    base = wr_q.size();
    drive_mm(1'b0, -1);
    wait_done();
    check_run(base, "replay");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
